// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder driver: FSM encoding and default width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/piso_shift.sv
// Parallel-load, LSB-first shift register feeding one serial operand line.
// Holds pure data, so it carries no reset; the owning FSM always loads before use.
module piso_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              lsb
);

  logic [DATA_W-1:0] sr_p0;

  // Load wins over shift; shifting moves the next operand bit into position 0.
  always_ff @(posedge clk) begin
    if (load) begin
      sr_p0 <= din;
    end else if (shift) begin
      sr_p0 <= {1'b0, sr_p0[DATA_W-1:1]};
    end
  end

  assign lsb = sr_p0[0];

endmodule

// File: rtl/serial_add_driver.sv
// Transmit-side driver for the bit-serial adder: accepts an operand pair,
// clears the adder carry with one zero cycle, streams the operands LSB-first,
// reassembles the returned sum bits and captures the final carry.
module serial_add_driver
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             a,
  output logic             b,
  input  logic             q,
  input  logic             state,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [1:0]    st;
  logic [CW-1:0] cnt;
  logic          a_lsb;
  logic          b_lsb;
  logic          load;
  logic          shift_en;
  logic          last_bit;

  assign in_ready = (st == ST_IDLE);
  assign load     = in_valid && in_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));
  // The FLUSH->SHIFT edge already consumes bit 0, so the registers advance there too.
  assign shift_en = (st == ST_FLUSH) || ((st == ST_SHIFT) && !last_bit);

  piso_shift #(.DATA_W(WIDTH)) u_sr_a (
    .clk   (clk),
    .load  (load),
    .shift (shift_en),
    .din   (op_a),
    .lsb   (a_lsb)
  );

  piso_shift #(.DATA_W(WIDTH)) u_sr_b (
    .clk   (clk),
    .load  (load),
    .shift (shift_en),
    .din   (op_b),
    .lsb   (b_lsb)
  );

  // Sequencer: drives a/b, collects q into sum and captures the carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      cnt       <= '0;
      a         <= 1'b0;
      b         <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          a <= 1'b0;
          b <= 1'b0;
          if (load) begin
            st <= ST_FLUSH;
          end
        end
        // a=b=0 during this cycle forces the adder carry to 0 at its end.
        ST_FLUSH: begin
          st  <= ST_SHIFT;
          cnt <= '0;
          a   <= a_lsb;
          b   <= b_lsb;
        end
        // Sum bits arrive LSB-first; after WIDTH shifts bit k sits in sum[k].
        ST_SHIFT: begin
          sum <= {q, sum[WIDTH-1:1]};
          if (last_bit) begin
            st <= ST_DONE;
            a  <= 1'b0;
            b  <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
            a   <= a_lsb;
            b   <= b_lsb;
          end
        end
        // First DONE cycle: the adder flop holds the carry out of bit WIDTH-1.
        ST_DONE: begin
          if (!out_valid) begin
            carry     <= state;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            st        <= ST_IDLE;
          end
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_driver.sv
// Bench for serial_add_driver paired with a behavioural bit-serial adder.
// Stimulus pushes expected {carry,sum} into a queue; a monitor pops on each
// output handshake and also checks that held results stay stable.
module tb_serial_add_driver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             a;
  logic             b;
  logic             q;
  logic             state;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;

  // Adder model: starts with a stale carry of 1 so the first flush matters.
  logic adder_state = 1'b1;
  assign state = adder_state;
  assign q     = a ^ b ^ adder_state;
  always @(posedge clk) adder_state <= (a & b) | (adder_state & (a ^ b));

  always #5 clk = ~clk;

  serial_add_driver #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .a         (a),
    .b         (b),
    .q         (q),
    .state     (state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry)
  );

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [WIDTH:0] exp_q[$];
  logic           rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on each handshake and check that stalled results are held.
  logic             prev_stall = 1'b0;
  logic [WIDTH:0]   prev_res   = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_result", {23'd0, carry, sum}, {23'd0, prev_res});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", {23'd0, carry, sum}, 32'hFFFF_FFFF);
        end else begin
          chk("result", {23'd0, carry, sum}, {23'd0, exp_q.pop_front()});
        end
      end
    end
    prev_stall = out_valid && !out_ready && !rst;
    prev_res   = {carry, sum};
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input bit push);
    int t = 0;
    while (!in_ready && t < 200) begin
      step();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    op_a     = x;
    op_b     = y;
    if (push) exp_q.push_back({1'b0, x} + {1'b0, y});
    step();
    in_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] va, vb;
  logic [WIDTH-1:0] tab_a [6] = '{8'h80, 8'h7F, 8'hA5, 8'hC3, 8'h0F, 8'hFE};
  logic [WIDTH-1:0] tab_b [6] = '{8'h80, 8'h01, 8'h5A, 8'h3C, 8'hF0, 8'h03};

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ab", {30'd0, a, b}, 32'd0);
    chk("rst_sum_carry", {23'd0, carry, sum}, 32'd0);
    rst = 1'b0;
    step();

    // Basic add with bit-level timing of the serial stream.
    va = 8'h05;
    vb = 8'h03;
    send(va, vb, 1'b1);
    chk("flush_ab", {30'd0, a, b}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < WIDTH; k++) begin
      step();
      chk("shift_ab", {30'd0, a, b}, {30'd0, va[k], vb[k]});
    end
    step();
    chk("done_pre_valid", {31'd0, out_valid}, 32'd0);
    chk("done_ab", {30'd0, a, b}, 32'd0);
    step();
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    step();
    chk("post_xfer_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_xfer_valid", {31'd0, out_valid}, 32'd0);

    // Overflow and back-to-back carry flush.
    send(8'hFF, 8'h01, 1'b1);
    send(8'hFF, 8'hFF, 1'b1);
    send(8'h00, 8'h00, 1'b1);

    // Backpressure with new operands offered while busy.
    send(8'h00, 8'h00, 1'b0);
    exp_q.push_back(9'h000);
    while (!in_ready) step();
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1);
    for (int t = 0; t < 30 && !out_valid; t++) step();
    chk("bp_valid_rise", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      op_a     = 8'h77;
      op_b     = 8'h11;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {23'd0, carry, sum}, 32'h046);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of shifting bit 3.
    send(8'hAA, 8'h55, 1'b0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_ab", {30'd0, a, b}, 32'd0);
    chk("mid_rst_sum", {24'd0, sum}, 32'd0);
    send(8'h01, 8'h01, 1'b1);

    // Directed table, then a sweep with random out_ready.
    for (int i = 0; i < 6; i++) send(tab_a[i], tab_b[i], 1'b1);
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) send(8'($urandom), 8'($urandom), 1'b1);
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) step();
    step();
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
